// File: rtl/load_store_unit_if.sv
// Request / data-memory bundle of the load-store unit.
// slave: LSU side. master: requester plus data memory side.
//   req_valid, is_load, size, sign_ext, addr, wdata : request
//   mem_addr, mem_re, mem_we, mem_be, mem_wdata     : memory command
//   mem_rdata                                       : memory read data
//   busy, done, rdata, err                          : status / result
interface load_store_unit_if #(
    parameter int ADDR_W = 30
);
    logic              req_valid;
    logic              is_load;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              err;

    modport slave (
        input  req_valid, is_load, size, sign_ext, addr, wdata,
        input  mem_rdata,
        output mem_addr, mem_re, mem_we, mem_be, mem_wdata,
        output busy, done, rdata, err
    );

    modport master (
        output req_valid, is_load, size, sign_ext, addr, wdata,
        output mem_rdata,
        input  mem_addr, mem_re, mem_we, mem_be, mem_wdata,
        input  busy, done, rdata, err
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access stage: byte/half/word loads and stores on a
// word-wide sync-read memory, misaligned accesses split in two words.
// Ports:
//   CLK, RESET : clock, async active-high reset
//   bus        : load_store_unit_if.slave (request, memory, status)
module load_store_unit #(
    parameter int ADDR_W           = 30,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                CLK,
    input  logic                RESET,
    load_store_unit_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_REQ1,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_is_load;
    logic [1:0]        r_size;
    logic              r_sign;
    logic [1:0]        r_off;
    logic              r_mis;
    logic [ADDR_W-1:0] r_w0;
    logic [31:0]       r_wdata;
    logic [31:0]       r_lo;

    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_rdata;

    function automatic logic [3:0] size_mask(input logic [1:0] s);
        logic [3:0] m;
        m = 4'b0000;
        unique case (s)
            2'b01:   m = 4'b0001;
            2'b10:   m = 4'b0011;
            2'b11:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    logic              w_accept;
    logic [1:0]        w_off;
    logic              w_mis;
    logic [ADDR_W-1:0] w_w0;
    logic [ADDR_W-1:0] w_w1;
    logic [3:0]        w_mask_in;
    logic [3:0]        w_mask_r;
    logic [3:0]        w_be0;
    logic [31:0]       w_wd0;
    logic [2:0]        w_rem;
    logic [3:0]        w_be1;
    logic [31:0]       w_wd1;
    logic [63:0]       w_pair;
    logic [31:0]       w_sh;
    logic [31:0]       w_ld;

    assign w_accept  = bus.req_valid && (bus.size != 2'b00);
    assign w_off     = bus.addr[1:0];
    assign w_mis     = (bus.size == 2'b10 && w_off == 2'b11)
                    || (bus.size == 2'b11 && w_off != 2'b00);
    assign w_w0      = bus.addr[ADDR_W+1:2];
    // Second word wraps from the top of the word space back to 0.
    assign w_w1      = r_w0 + ADDR_W'(1);
    assign w_mask_in = size_mask(bus.size);
    assign w_mask_r  = size_mask(r_size);
    assign w_be0     = w_mask_in << w_off;
    assign w_wd0     = bus.wdata << {w_off, 3'b000};
    // Bytes that spilled past lane 3 in the first word.
    assign w_rem     = 3'd4 - {1'b0, r_off};
    assign w_be1     = w_mask_r >> w_rem;
    assign w_wd1     = r_wdata >> {w_rem, 3'b000};

    // Split loads: lo captured in REQ1, hi arrives now.
    assign w_pair = r_mis ? {bus.mem_rdata, r_lo}
                          : {32'h0, bus.mem_rdata};
    assign w_sh   = 32'(w_pair >> {r_off, 3'b000});

    always_comb begin
        w_ld = w_sh;
        unique case (r_size)
            2'b01:   w_ld = {{24{r_sign & w_sh[7]}}, w_sh[7:0]};
            2'b10:   w_ld = {{16{r_sign & w_sh[15]}}, w_sh[15:0]};
            default: w_ld = w_sh;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_is_load   <= 1'b0;
            r_size      <= 2'b00;
            r_sign      <= 1'b0;
            r_off       <= 2'b00;
            r_mis       <= 1'b0;
            r_w0        <= '0;
            r_wdata     <= 32'h0;
            r_lo        <= 32'h0;
            r_mem_addr  <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
        end else begin
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_mem_be <= 4'b0000;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_load <= bus.is_load;
                        r_size    <= bus.size;
                        r_sign    <= bus.sign_ext;
                        r_off     <= w_off;
                        r_mis     <= w_mis;
                        r_w0      <= w_w0;
                        r_wdata   <= bus.wdata;
                        r_busy    <= 1'b1;
                        if (!ALLOW_MISALIGNED && w_mis) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= S_REQ0;
                            r_mem_addr  <= w_w0;
                            r_mem_re    <= bus.is_load;
                            r_mem_we    <= !bus.is_load;
                            r_mem_be    <= w_be0;
                            r_mem_wdata <= w_wd0;
                        end
                    end
                end
                S_REQ0: begin
                    if (r_mis) begin
                        r_state     <= S_REQ1;
                        r_mem_addr  <= w_w1;
                        r_mem_re    <= r_is_load;
                        r_mem_we    <= !r_is_load;
                        r_mem_be    <= w_be1;
                        r_mem_wdata <= w_wd1;
                    end else if (r_is_load) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_REQ1: begin
                    r_lo <= bus.mem_rdata;
                    if (r_is_load) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_rdata <= w_ld;
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_re    = r_mem_re;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory, scoreboard
// of expected results, directed lane checks and a random sweep.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(30)) b0 ();
    load_store_unit_if #(.ADDR_W(30)) b1 ();

    load_store_unit #(.ADDR_W(30), .ALLOW_MISALIGNED(1'b1)) u0 (
        .CLK(clk), .RESET(rst), .bus(b0)
    );
    load_store_unit #(.ADDR_W(30), .ALLOW_MISALIGNED(1'b0)) u1 (
        .CLK(clk), .RESET(rst), .bus(b1)
    );

    logic        sel = 1'b0;
    logic        rv = 1'b0;
    logic        ld = 1'b0;
    logic [1:0]  sz = 2'b00;
    logic        sx = 1'b0;
    logic [31:0] ad = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] mrd0 = 32'h0;

    assign b0.req_valid = rv & ~sel;
    assign b1.req_valid = rv & sel;
    assign b0.is_load = ld;
    assign b1.is_load = ld;
    assign b0.size = sz;
    assign b1.size = sz;
    assign b0.sign_ext = sx;
    assign b1.sign_ext = sx;
    assign b0.addr = ad;
    assign b1.addr = ad;
    assign b0.wdata = wd;
    assign b1.wdata = wd;
    assign b0.mem_rdata = mrd0;
    assign b1.mem_rdata = 32'h12345678;

    logic        o_done, o_err, o_busy, o_re, o_we;
    logic [31:0] o_rdata, o_wd;
    logic [29:0] o_addr;
    logic [3:0]  o_be;
    assign o_done  = sel ? b1.done : b0.done;
    assign o_err   = sel ? b1.err : b0.err;
    assign o_busy  = sel ? b1.busy : b0.busy;
    assign o_re    = sel ? b1.mem_re : b0.mem_re;
    assign o_we    = sel ? b1.mem_we : b0.mem_we;
    assign o_rdata = sel ? b1.rdata : b0.rdata;
    assign o_wd    = sel ? b1.mem_wdata : b0.mem_wdata;
    assign o_addr  = sel ? b1.mem_addr : b0.mem_addr;
    assign o_be    = sel ? b1.mem_be : b0.mem_be;

    logic [31:0] wmem [int unsigned];
    logic [7:0]  emem [int unsigned];

    function automatic logic [31:0] rdw(input logic [29:0] w);
        return wmem.exists(w) ? wmem[w] : 32'h0;
    endfunction

    function automatic logic [7:0] mb(input logic s, input logic [31:0] ba);
        logic [31:0] c;
        c = 32'h12345678;
        if (s) return c[8*ba[1:0] +: 8];
        return emem.exists(ba) ? emem[ba] : 8'h00;
    endfunction

    function automatic logic [31:0] mw(input logic [29:0] w);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = mb(1'b0, {w, 2'b00} + i);
        return v;
    endfunction

    task automatic preload(input logic [29:0] w, input logic [31:0] v);
        wmem[w] = v;
        for (int i = 0; i < 4; i++) emem[{w, 2'b00} + i] = v[8*i +: 8];
    endtask

    logic [31:0] tw;
    always @(posedge clk) begin
        if (b0.mem_re) mrd0 <= rdw(b0.mem_addr);
        if (b0.mem_we) begin
            tw = rdw(b0.mem_addr);
            for (int k = 0; k < 4; k++)
                if (b0.mem_be[k]) tw[8*k +: 8] = b0.mem_wdata[8*k +: 8];
            wmem[b0.mem_addr] = tw;
        end
    end

    int viol = 0;
    int st1 = 0;
    always @(negedge clk) begin
        if (b0.mem_re && b0.mem_we) viol++;
        if (b0.mem_be != 4'b0 && !(b0.mem_re || b0.mem_we)) viol++;
        if (b1.mem_re && b1.mem_we) viol++;
        if (b1.mem_re || b1.mem_we) st1++;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sbq [$];

    logic [31:0] held [2];
    logic [29:0] s0_addr, s1_addr;
    logic [3:0]  s0_be, s1_be;
    logic [31:0] s0_wd, s1_wd;
    logic        s0_re, s0_we, s1_re, s1_we;

    task automatic do_req(input logic s, input logic l, input logic [1:0] z,
                          input logic x, input logic [31:0] a,
                          input logic [31:0] d);
        exp_t e;
        logic mis;
        int nb;
        int n;
        logic got;
        logic [31:0] v;
        nb  = (z == 2'd1) ? 1 : (z == 2'd2) ? 2 : 4;
        mis = (z == 2'd2 && a[1:0] == 2'd3) || (z == 2'd3 && a[1:0] != 2'd0);
        e.err = s && mis;
        if (e.err) e.lat = 1;
        else if (l) e.lat = mis ? 4 : 3;
        else e.lat = mis ? 3 : 2;
        if (l && !e.err) begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mb(s, a + i);
            if (x && nb == 1) v = {{24{v[7]}}, v[7:0]};
            if (x && nb == 2) v = {{16{v[15]}}, v[15:0]};
            held[s] = v;
        end
        e.rdata = held[s];
        sbq.push_back(e);
        sel = s; ld = l; sz = z; sx = x; ad = a; wd = d; rv = 1'b1;
        @(posedge clk);
        #1 rv = 1'b0;
        n = 1;
        got = 1'b0;
        while (!got && n <= 8) begin
            @(negedge clk);
            if (n == 1) begin
                s0_addr = o_addr; s0_be = o_be; s0_wd = o_wd;
                s0_re = o_re; s0_we = o_we;
            end
            if (n == 2) begin
                s1_addr = o_addr; s1_be = o_be; s1_wd = o_wd;
                s1_re = o_re; s1_we = o_we;
            end
            if (o_done) got = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        e = sbq.pop_front();
        if (!got) begin
            chk("done_timeout", {63'h0, o_done}, 64'h1);
        end else begin
            chk("rdata", {32'h0, o_rdata}, {32'h0, e.rdata});
            chk("err", {63'h0, o_err}, {63'h0, e.err});
            chk("latency", 64'(n), 64'(e.lat));
            if (!l && !e.err && !s) begin
                for (int i = 0; i < nb; i++) emem[a + i] = d[8*i +: 8];
                chk("mem_w0", {32'h0, rdw(a[31:2])}, {32'h0, mw(a[31:2])});
                chk("mem_w1", {32'h0, rdw(a[31:2] + 30'd1)},
                    {32'h0, mw(a[31:2] + 30'd1)});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    int cnt;
    logic [31:0] ra;
    logic [1:0]  rz;

    initial begin
        held[0] = 32'h0;
        held[1] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'h0, b0.busy}, 64'h0);
        chk("rst_done", {62'h0, b0.done, b1.done}, 64'h0);
        chk("rst_err", {62'h0, b0.err, b1.err}, 64'h0);
        chk("rst_rdata", {32'h0, b0.rdata}, 64'h0);
        chk("rst_strobe", {58'h0, b0.mem_re, b0.mem_we, b0.mem_be}, 64'h0);
        chk("rst_maddr", {34'h0, b0.mem_addr}, 64'h0);
        chk("rst_mwdata", {32'h0, b0.mem_wdata}, 64'h0);

        do_req(1'b0, 1'b0, 2'd1, 1'b0, 32'h103, 32'hAB);
        chk("t1_addr", {34'h0, s0_addr}, 64'h40);
        chk("t1_be", {60'h0, s0_be}, 64'h8);
        chk("t1_wdata", {32'h0, s0_wd}, 64'hAB000000);
        chk("t1_we", {62'h0, s0_we, s0_re}, 64'h2);

        preload(30'h40, 32'h44332211);
        preload(30'h41, 32'h88776655);
        do_req(1'b0, 1'b1, 2'd3, 1'b0, 32'h102, 32'h0);
        chk("t2_rdata", {32'h0, o_rdata}, 64'h66554433);
        chk("t2_req0", {33'h0, s0_re, s0_addr}, {33'h1, 30'h40});
        chk("t2_req1", {33'h0, s1_re, s1_addr}, {33'h1, 30'h41});

        preload(30'h40, 32'h000080FF);
        do_req(1'b0, 1'b1, 2'd1, 1'b1, 32'h101, 32'h0);
        chk("t3_sext", {32'h0, o_rdata}, 64'hFFFFFF80);
        do_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h101, 32'h0);
        chk("t3_zext", {32'h0, o_rdata}, 64'h80);

        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFF, 32'hBEEF);
        chk("t4_addr0", {34'h0, s0_addr}, 64'h3FFFFFFF);
        chk("t4_be0", {60'h0, s0_be}, 64'h8);
        chk("t4_wd0", {56'h0, s0_wd[31:24]}, 64'hEF);
        chk("t4_addr1", {34'h0, s1_addr}, 64'h0);
        chk("t4_be1", {60'h0, s1_be}, 64'h1);
        chk("t4_wd1", {56'h0, s1_wd[7:0]}, 64'hBE);

        sel = 1'b0; ld = 1'b0; sz = 2'd3; sx = 1'b0;
        ad = 32'h201; wd = 32'h11223344; rv = 1'b1;
        @(posedge clk);
        #1 rv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_we_req1", {63'h0, o_we}, 64'h1);
        rst = 1'b1;
        #1;
        chk("t5_we_rst", {63'h0, o_we}, 64'h0);
        chk("t5_busy_rst", {63'h0, o_busy}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        held[0] = 32'h0;
        held[1] = 32'h0;
        for (int i = 0; i < 3; i++) emem[32'h201 + i] = wd[8*i +: 8];
        chk("t5_half", {32'h0, rdw(30'h80)}, 64'h22334400);
        chk("t5_rdata", {32'h0, o_rdata}, 64'h0);
        @(negedge clk);
        ad = 32'h300; wd = 32'hCAFEF00D; rv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ad = 32'h304; wd = 32'hDEADBEEF;
        @(posedge clk);
        #1 rv = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done) cnt++;
        end
        for (int i = 0; i < 4; i++) emem[32'h300 + i] = 8'(32'hCAFEF00D >> (8*i));
        chk("t5_one_done", 64'(cnt), 64'h1);
        chk("t5_mem_c0", {32'h0, rdw(30'hC0)}, 64'hCAFEF00D);
        chk("t5_mem_c1", {32'h0, rdw(30'hC1)}, 64'h0);

        do_req(1'b1, 1'b1, 2'd3, 1'b0, 32'h4, 32'h0);
        do_req(1'b1, 1'b1, 2'd3, 1'b0, 32'h2, 32'h0);
        chk("t6_rdata_held", {32'h0, o_rdata}, 64'h12345678);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h3, 32'h5555);
        do_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h3, 32'h66);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'hFFFFFFF0;
            ra = ra + 32'($urandom_range(0, 15));
            rz = 2'($urandom_range(1, 3));
            do_req(1'b0, 1'($urandom_range(0, 1)), rz,
                   1'($urandom_range(0, 1)), ra, $urandom());
        end

        chk("re_we_excl", 64'(viol), 64'h0);
        chk("dut1_strobes", 64'(st1), 64'h2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
